// File: rtl/la_sample_fifo.sv
// Circular sample buffer behind the LA capture FSM; the host reads samples oldest-first
// through a register-bus daisy-chain window starting at BASE_ADDR.
module la_sample_fifo #(
  parameter int BASE_ADDR    = 0,
  parameter int SAMPLE_DEPTH = 8,
  parameter int WIDTH        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                probe,
  input  logic                            acquire,
  input  logic                            pop,
  input  logic                            clear,
  output logic [$clog2(SAMPLE_DEPTH):0]   size,
  input  logic [15:0]                     addr_i,
  input  logic [15:0]                     wdata_i,
  input  logic [15:0]                     rdata_i,
  input  logic                            rw_i,
  input  logic                            valid_i,
  output logic [15:0]                     addr_o,
  output logic [15:0]                     wdata_o,
  output logic [15:0]                     rdata_o,
  output logic                            rw_o,
  output logic                            valid_o
);
  localparam int PW  = $clog2(SAMPLE_DEPTH);
  localparam int SW  = PW + 1;
  localparam logic [PW-1:0] LAST = PW'(SAMPLE_DEPTH - 1);
  localparam logic [SW-1:0] FULL = SW'(SAMPLE_DEPTH);

  logic [WIDTH-1:0] mem [SAMPLE_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]    size_q, size_d;
  logic             wr_en, rd_en;

  logic [16:0]      off, n;
  logic             owned;
  logic [SW-1:0]    idx_sum;
  logic [PW-1:0]    idx;
  logic [15:0]      rdata_d;
  logic [15:0]      addr_q, wdata_q, rdata_q;
  logic             rw_q, valid_q;

  // A pop alongside an acquire frees the slot, so a full buffer still slides.
  always_comb begin
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    size_d   = size_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      size_d   = '0;
    end else begin
      wr_en = acquire && ((size_q != FULL) || pop);
      rd_en = pop && (size_q != '0);
      if (wr_en) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      if (wr_en && !rd_en)      size_d = size_q + 1'b1;
      else if (!wr_en && rd_en) size_d = size_q - 1'b1;
    end
  end

  always_comb begin
    off     = {1'b0, addr_i} - 17'(BASE_ADDR);
    owned   = !off[16] && (off <= 17'(SAMPLE_DEPTH));
    n       = off - 17'd1;
    idx_sum = {1'b0, rd_ptr_q} + n[PW:0];
    if (idx_sum >= FULL) idx_sum = idx_sum - FULL;
    idx     = idx_sum[PW-1:0];
    rdata_d = rdata_i;
    if (valid_i && !rw_i && owned) begin
      if (off == 17'd0)            rdata_d = 16'(size_q);
      else if (n < 17'(size_q))    rdata_d = 16'(mem[idx]);
      else                         rdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rw_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      size_q   <= size_d;
      addr_q   <= addr_i;
      wdata_q  <= wdata_i;
      rdata_q  <= rdata_d;
      rw_q     <= rw_i;
      valid_q  <= valid_i;
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= probe;
  end

  assign size    = size_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;
  assign rw_o    = rw_q;
  assign valid_o = valid_q;
endmodule

// File: tb/tb_la_sample_fifo.sv
// Bench for la_sample_fifo: vector table, directed corner sequences and random traffic
// against a queue-based occupancy/readback model.
module tb_la_sample_fifo;
  localparam int BASE = 0;
  localparam int D    = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  probe = '0;
  logic        acquire = 1'b0, pop = 1'b0, clear = 1'b0;
  logic [3:0]  size;
  logic [15:0] addr_i = '0, wdata_i = '0, rdata_i = '0;
  logic        rw_i = 1'b0, valid_i = 1'b0;
  logic [15:0] addr_o, wdata_o, rdata_o;
  logic        rw_o, valid_o;

  la_sample_fifo #(.BASE_ADDR(BASE), .SAMPLE_DEPTH(D), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .probe(probe), .acquire(acquire), .pop(pop), .clear(clear),
    .size(size), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i),
    .valid_i(valid_i), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o),
    .rw_o(rw_o), .valid_o(valid_o));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int q[$];

  typedef struct {
    logic a, p, c; logic [7:0] pr; logic v, rw; logic [15:0] ad, rin;
    logic [3:0] esize; logic [15:0] erd;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected bus readback from the buffer contents seen before the clock edge.
  function automatic logic [15:0] m_read(input logic v, input logic rwv,
                                         input logic [15:0] ad, input logic [15:0] rin);
    int o;
    o = int'(ad) - BASE;
    if (v && !rwv && o >= 0 && o <= D) begin
      if (o == 0) return 16'(q.size());
      return (o - 1 < q.size()) ? 16'(q[o-1]) : 16'h0;
    end
    return rin;
  endfunction

  task automatic m_update(input logic a, input logic p, input logic c, input logic [7:0] pr);
    if (c) q.delete();
    else if (a && p) begin
      if (q.size() != 0) void'(q.pop_front());
      q.push_back(int'(pr));
    end else if (a) begin
      if (q.size() < D) q.push_back(int'(pr));
    end else if (p) begin
      if (q.size() != 0) void'(q.pop_front());
    end
  endtask

  // Called #1 after a rising edge; drives one cycle and checks all outputs against the model.
  task automatic step(input string nm, input logic a, input logic p, input logic c,
                      input logic [7:0] pr, input logic v, input logic rwv,
                      input logic [15:0] ad, input logic [15:0] wd, input logic [15:0] rin);
    logic [15:0] erd;
    acquire = a; pop = p; clear = c; probe = pr;
    valid_i = v; rw_i = rwv; addr_i = ad; wdata_i = wd; rdata_i = rin;
    erd = m_read(v, rwv, ad, rin);
    m_update(a, p, c, pr);
    @(posedge clk); #1;
    chk({nm, ".size"}, 32'(size), 32'(q.size()));
    chk({nm, ".rdata_o"}, 32'(rdata_o), 32'(erd));
    chk({nm, ".addr_o"}, 32'(addr_o), 32'(ad));
    chk({nm, ".wdata_o"}, 32'(wdata_o), 32'(wd));
    chk({nm, ".ctl_o"}, {30'd0, rw_o, valid_o}, {30'd0, rwv, v});
  endtask

  task automatic acq(input string nm, input logic [7:0] pr);
    step(nm, 1'b1, 1'b0, 1'b0, pr, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic rd(input string nm, input int off);
    step(nm, 1'b0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 16'(BASE + off), 16'h0, 16'hDEAD);
  endtask

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,16'(BASE+0),16'h1234,4'd0,16'h0000};
    tbl[1]  = '{1'b1,1'b0,1'b0,8'hA1,1'b0,1'b0,16'h0000,16'h1234,4'd1,16'h1234};
    tbl[2]  = '{1'b1,1'b0,1'b0,8'hA2,1'b0,1'b0,16'h0000,16'h1234,4'd2,16'h1234};
    tbl[3]  = '{1'b1,1'b0,1'b0,8'hA3,1'b0,1'b0,16'h0000,16'h1234,4'd3,16'h1234};
    tbl[4]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,16'(BASE+1),16'h1234,4'd3,16'h00A1};
    tbl[5]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,16'(BASE+2),16'h1234,4'd3,16'h00A2};
    tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,16'(BASE+3),16'h1234,4'd3,16'h00A3};
    tbl[7]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,16'(BASE+4),16'h1234,4'd3,16'h0000};
    tbl[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,16'(BASE+0),16'h1234,4'd3,16'h0003};
    tbl[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,16'(BASE+D+1),16'h1234,4'd3,16'h1234};
    tbl[10] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,16'(BASE+1),16'h1234,4'd3,16'h1234};

    repeat (2) @(posedge clk);
    #1;
    chk("reset.size", 32'(size), 32'd0);
    chk("reset.bus", {addr_o, wdata_o}, 32'd0);
    chk("reset.bus2", {rdata_o, 14'd0, rw_o, valid_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      step($sformatf("vec%0d", i), tbl[i].a, tbl[i].p, tbl[i].c, tbl[i].pr, tbl[i].v,
           tbl[i].rw, tbl[i].ad, 16'h5A5A, tbl[i].rin);
      chk($sformatf("vec%0d.tsize", i), 32'(size), 32'(tbl[i].esize));
      chk($sformatf("vec%0d.trdata", i), 32'(rdata_o), 32'(tbl[i].erd));
    end

    // Fill past full: later samples must be dropped.
    step("clr", 1'b0, 1'b0, 1'b1, 8'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int i = 1; i <= 10; i++) begin
      acq("fill", 8'(i));
      if (i >= 8) chk("fill.size8", 32'(size), 32'd8);
    end
    for (int k = 1; k <= 8; k++) begin
      rd("fillrd", k);
      chk("fill.data", 32'(rdata_o), 32'(k));
    end

    // Sliding window across the pointer wrap.
    step("clr", 1'b0, 1'b0, 1'b1, 8'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int i = 1; i <= 4; i++) acq("wrap.acq", 8'(i));
    for (int i = 5; i <= 10; i++)
      step("wrap.slide", 1'b1, 1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    chk("wrap.size", 32'(size), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      rd("wraprd", k);
      chk("wrap.data", 32'(rdata_o), 32'(k + 6));
    end

    // Clear beats a simultaneous acquire and pop.
    for (int i = 0; i < 5; i++) acq("pre5", 8'(8'h30 + i));
    step("clrall", 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    chk("clrall.size", 32'(size), 32'd0);
    acq("a55", 8'h55);
    rd("rd55", 1);
    chk("a55.data", 32'(rdata_o), 32'h55);
    step("pop1", 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    step("popempty", 1'b0, 1'b1, 1'b0, 8'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    chk("popempty.size", 32'(size), 32'd0);
    step("apempty", 1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    chk("apempty.size", 32'(size), 32'd1);

    // Asynchronous reset mid-fill.
    step("clr", 1'b0, 1'b0, 1'b1, 8'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) acq("mid", 8'(8'h40 + i));
    step("mid6", 1'b1, 1'b0, 1'b0, 8'h45, 1'b1, 1'b0, 16'(BASE), 16'h0, 16'h0);
    chk("mid.size6", 32'(size), 32'd6);
    acquire = 1'b0; valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.size", 32'(size), 32'd0);
    chk("arst.valid_o", 32'(valid_o), 32'd0);
    q.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    acq("post.a", 8'h11);
    acq("post.b", 8'h22);
    step("wr2", 1'b0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1, 16'(BASE + 2), 16'hCAFE, 16'h0);
    chk("wr2.wdata_o", 32'(wdata_o), 32'hCAFE);
    rd("rd1", 1);
    chk("post.mem0", 32'(rdata_o), 32'h11);
    rd("rd2", 2);
    chk("post.mem1", 32'(rdata_o), 32'h22);

    for (int i = 0; i < 600; i++)
      step("rand", 1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0),
           8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, D + 2)),
           16'($urandom), 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
